// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants and types for the multicycle control unit: FSM state
// encodings, opcode map, ALU class codes, instruction classes and the
// control-strobe payload driven by the decoder.
package multicycle_control_unit_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned STATE_W  = 3;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned COUNT_W  = 16;

   // Encodings 5-7 are unused and recover to S_FETCH
   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   localparam logic [OPCODE_W-1:0] OP_LD      = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ST      = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_R_FIRST = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_R_LAST  = 4'h9;
   localparam logic [OPCODE_W-1:0] OP_BEQ     = 4'hB;
   localparam logic [OPCODE_W-1:0] OP_BNE     = 4'hC;
   localparam logic [OPCODE_W-1:0] OP_JMP     = 4'hD;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALU_CMP   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALU_RTYPE = 2'b10;

   typedef enum logic [2:0] {
      C_LD,
      C_ST,
      C_RTYPE,
      C_BEQ,
      C_BNE,
      C_JMP,
      C_ILLEGAL
   } op_class_e;

   typedef struct packed {
      logic               jump;
      logic               beq;
      logic               bne;
      logic               mem_read;
      logic               mem_write;
      logic               alu_src;
      logic               reg_dst;
      logic               mem_to_reg;
      logic               reg_write;
      logic [ALUOP_W-1:0] alu_op;
      logic               ir_write;
      logic               pc_write;
      logic               illegal;
   } ctrl_t;

   // Opcode to instruction class; 1010, 1110 and 1111 are illegal
   function automatic op_class_e op_class(input logic [OPCODE_W-1:0] op);
      op_class_e c;
      if (op == OP_LD)                               c = C_LD;
      else if (op == OP_ST)                          c = C_ST;
      else if ((op >= OP_R_FIRST) && (op <= OP_R_LAST)) c = C_RTYPE;
      else if (op == OP_BEQ)                         c = C_BEQ;
      else if (op == OP_BNE)                         c = C_BNE;
      else if (op == OP_JMP)                         c = C_JMP;
      else                                           c = C_ILLEGAL;
      return c;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps (state, opcode, handshake inputs) to
// the datapath control strobes.
//   i_state      current FSM state
//   i_op         opcode in effect (live in DECODE, latched op_q afterwards)
//   i_en         run enable (FETCH only)
//   i_imem_ready instruction memory data valid
//   i_dmem_ready data memory access complete
//   o_ctrl       control strobe bundle
module ctrl_decode
   import multicycle_control_unit_pkg::*;
(
   input  state_e              i_state,
   input  logic [OPCODE_W-1:0] i_op,
   input  logic                i_en,
   input  logic                i_imem_ready,
   input  logic                i_dmem_ready,
   output ctrl_t               o_ctrl
);

   op_class_e w_class;

   assign w_class = op_class(i_op);

   // Every strobe defaults low; each state raises only what it owns
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.ir_write = i_en & i_imem_ready;
         end
         S_DECODE: begin
            if (w_class == C_ILLEGAL) begin
               o_ctrl.illegal  = 1'b1;
               o_ctrl.pc_write = 1'b1;
            end
         end
         S_EXEC: begin
            case (w_class)
               C_LD, C_ST: begin
                  o_ctrl.alu_op  = ALU_ADD;
                  o_ctrl.alu_src = 1'b1;
               end
               C_RTYPE: begin
                  o_ctrl.alu_op  = ALU_RTYPE;
                  o_ctrl.reg_dst = 1'b1;
               end
               C_BEQ: begin
                  o_ctrl.alu_op   = ALU_CMP;
                  o_ctrl.beq      = 1'b1;
                  o_ctrl.pc_write = 1'b1;
               end
               C_BNE: begin
                  o_ctrl.alu_op   = ALU_CMP;
                  o_ctrl.bne      = 1'b1;
                  o_ctrl.pc_write = 1'b1;
               end
               C_JMP: begin
                  o_ctrl.alu_op   = ALU_ADD;
                  o_ctrl.jump     = 1'b1;
                  o_ctrl.pc_write = 1'b1;
               end
               default: begin
               end
            endcase
         end
         S_MEM: begin
            // Access strobe held until the memory completes; a store retires here
            if (w_class == C_LD) begin
               o_ctrl.mem_read = 1'b1;
               o_ctrl.alu_src  = 1'b1;
            end else if (w_class == C_ST) begin
               o_ctrl.mem_write = 1'b1;
               o_ctrl.alu_src   = 1'b1;
               o_ctrl.pc_write  = i_dmem_ready;
            end
         end
         S_WB: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.pc_write   = 1'b1;
            o_ctrl.mem_to_reg = (w_class == C_LD);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with an
// opcode latch and a retired-instruction counter. Strobes come from the
// ctrl_decode sub-module and are forced low while reset is asserted.
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  run enable, sampled in FETCH
//   opcode              instruction opcode from the IR
//   imem_ready          instruction memory data valid
//   dmem_ready          data memory access complete
//   jump..reg_write     datapath control strobes
//   alu_op              ALU class (00 add, 01 compare, 10 R-type)
//   ir_write, pc_write  IR load, PC advance/redirect
//   state               current FSM state
//   illegal             one-cycle illegal-opcode pulse
//   retired_count       count of pc_write cycles, wraps at 16 bits
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                jump,
   output logic                beq,
   output logic                bne,
   output logic                mem_read,
   output logic                mem_write,
   output logic                alu_src,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                ir_write,
   output logic                pc_write,
   output logic [STATE_W-1:0]  state,
   output logic                illegal,
   output logic [COUNT_W-1:0]  retired_count
);

   state_e              r_state;
   logic [OPCODE_W-1:0] r_op_q;
   logic [COUNT_W-1:0]  r_retired;

   logic [OPCODE_W-1:0] w_op;
   op_class_e           w_live_class;
   op_class_e           w_q_class;
   ctrl_t               w_ctrl;
   ctrl_t               w_out;

   // DECODE acts on the live opcode; later states only see the latched copy
   assign w_op         = (r_state == S_DECODE) ? opcode : r_op_q;
   assign w_live_class = op_class(opcode);
   assign w_q_class    = op_class(r_op_q);

   ctrl_decode u_ctrl_decode (
      .i_state      (r_state),
      .i_op         (w_op),
      .i_en         (en),
      .i_imem_ready (imem_ready),
      .i_dmem_ready (dmem_ready),
      .o_ctrl       (w_ctrl)
   );

   // Strobes drop immediately with reset, not at the next edge
   assign w_out = rst_n ? w_ctrl : '0;

   assign jump          = w_out.jump;
   assign beq           = w_out.beq;
   assign bne           = w_out.bne;
   assign mem_read      = w_out.mem_read;
   assign mem_write     = w_out.mem_write;
   assign alu_src       = w_out.alu_src;
   assign reg_dst       = w_out.reg_dst;
   assign mem_to_reg    = w_out.mem_to_reg;
   assign reg_write     = w_out.reg_write;
   assign alu_op        = w_out.alu_op;
   assign ir_write      = w_out.ir_write;
   assign pc_write      = w_out.pc_write;
   assign illegal       = w_out.illegal;
   assign state         = r_state;
   assign retired_count = r_retired;

   // Sequencer, opcode latch and retirement counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_op_q    <= '0;
         r_retired <= '0;
      end else begin
         if (w_ctrl.pc_write) begin
            r_retired <= r_retired + COUNT_W'(1);
         end
         case (r_state)
            S_FETCH: begin
               if (en && imem_ready) begin
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_op_q  <= opcode;
               r_state <= (w_live_class == C_ILLEGAL) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
               case (w_q_class)
                  C_LD, C_ST: r_state <= S_MEM;
                  C_RTYPE:    r_state <= S_WB;
                  default:    r_state <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  r_state <= (w_q_class == C_LD) ? S_WB : S_FETCH;
               end
            end
            S_WB: begin
               r_state <= S_FETCH;
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: an instruction-level plan
// model (queue of remaining steps per instruction) checked every cycle, plus
// directed scenarios with hand-computed latencies and strobe tallies.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  opcode;
   logic        imem_ready;
   logic        dmem_ready;
   logic        jump, beq, bne, mem_read, mem_write, alu_src, reg_dst;
   logic        mem_to_reg, reg_write, ir_write, pc_write, illegal;
   logic [1:0]  alu_op;
   logic [2:0]  state;
   logic [15:0] retired_count;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .opcode        (opcode),
      .imem_ready    (imem_ready),
      .dmem_ready    (dmem_ready),
      .jump          (jump),
      .beq           (beq),
      .bne           (bne),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .alu_src       (alu_src),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_op        (alu_op),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .state         (state),
      .illegal       (illegal),
      .retired_count (retired_count)
   );

   localparam int C_LD = 0, C_ST = 1, C_R = 2, C_BEQ = 3, C_BNE = 4, C_JMP = 5, C_ILL = 6;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cyc    = 0;

   // Model: remaining steps of the current instruction (front = this cycle)
   int m_plan[$];
   int m_cls   = 0;
   int m_count = 0;

   int t_cyc, t_seq, t_pw, t_rw, t_mr, t_mw, t_il, t_mtr, t_rd;
   int t_beq, t_bne, t_jmp, t_aoc, t_aor, t_other;

   function automatic int cls_of(input logic [3:0] op);
      int v;
      v = int'(op);
      if (v == 0)              return C_LD;
      if (v == 1)              return C_ST;
      if (v >= 2 && v <= 9)    return C_R;
      if (v == 11)             return C_BEQ;
      if (v == 12)             return C_BNE;
      if (v == 13)             return C_JMP;
      return C_ILL;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, n_cyc, act, exp);
      end
   endtask

   function automatic logic [13:0] act_vec();
      return {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg,
              reg_write, alu_op, ir_write, pc_write, illegal};
   endfunction

   // Per-cycle comparison against the plan model, then advance the model
   task automatic model_check();
      logic ej, eb, ebn, emr, emw, eas, erd, emtr, erw, eirw, epw, eil;
      logic [1:0] eao;
      int cur;
      int lc;
      {ej, eb, ebn, emr, emw, eas, erd, emtr, erw, eirw, epw, eil} = '0;
      eao = 2'b00;
      if (!rst_n) begin
         m_plan.delete();
         m_count = 0;
         chk("reset_strobes", 32'(act_vec()), 32'd0);
         chk("reset_state", 32'(state), 32'd0);
         chk("reset_count", 32'(retired_count), 32'd0);
      end else begin
         cur = (m_plan.size() != 0) ? m_plan[0] : 0;
         lc  = cls_of(opcode);
         case (cur)
            0: eirw = en & imem_ready;
            1: if (lc == C_ILL) begin eil = 1'b1; epw = 1'b1; end
            2: begin
               if (m_cls == C_LD || m_cls == C_ST) eas = 1'b1;
               if (m_cls == C_R)   begin erd = 1'b1; eao = 2'b10; end
               if (m_cls == C_BEQ) begin eb  = 1'b1; eao = 2'b01; epw = 1'b1; end
               if (m_cls == C_BNE) begin ebn = 1'b1; eao = 2'b01; epw = 1'b1; end
               if (m_cls == C_JMP) begin ej  = 1'b1; epw = 1'b1; end
            end
            3: begin
               eas = 1'b1;
               if (m_cls == C_LD) emr = 1'b1;
               else begin emw = 1'b1; epw = dmem_ready; end
            end
            default: begin erw = 1'b1; epw = 1'b1; emtr = (m_cls == C_LD); end
         endcase
         chk("strobes", 32'(act_vec()),
             32'({ej, eb, ebn, emr, emw, eas, erd, emtr, erw, eao, eirw, epw, eil}));
         chk("state", 32'(state), 32'(cur));
         chk("retired_count", 32'(retired_count), 32'(m_count));
         if (epw) m_count = (m_count + 1) % 65536;
         case (cur)
            0: if (en && imem_ready) m_plan.push_back(1);
            1: begin
               void'(m_plan.pop_front());
               m_cls = lc;
               case (lc)
                  C_LD:                m_plan = '{2, 3, 4};
                  C_ST:                m_plan = '{2, 3};
                  C_R:                 m_plan = '{2, 4};
                  C_BEQ, C_BNE, C_JMP: m_plan = '{2};
                  default:             m_plan.delete();
               endcase
            end
            3: if (dmem_ready) void'(m_plan.pop_front());
            default: void'(m_plan.pop_front());
         endcase
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_check();
      n_cyc++;
      @(posedge clk);
      #1;
   endtask

   // Run one instruction from FETCH back to FETCH, tallying strobes
   task automatic do_instr(input logic [3:0] op, input int nwait);
      int  waited;
      bit  done;
      waited = 0;
      done   = 0;
      {t_cyc, t_seq, t_pw, t_rw, t_mr, t_mw, t_il, t_mtr, t_rd} = '0;
      {t_beq, t_bne, t_jmp, t_aoc, t_aor, t_other} = '0;
      en = 1'b1; imem_ready = 1'b1; opcode = op; dmem_ready = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (state == 3'd3) begin
            dmem_ready = (waited >= nwait);
            waited++;
         end else begin
            dmem_ready = 1'b0;
         end
         #1;
         t_cyc++;
         t_seq = t_seq * 8 + int'(state);
         if (pc_write)        t_pw++;
         if (reg_write)       t_rw++;
         if (mem_read)        t_mr++;
         if (mem_write)       t_mw++;
         if (illegal)         t_il++;
         if (mem_to_reg)      t_mtr++;
         if (reg_dst)         t_rd++;
         if (beq)             t_beq++;
         if (bne)             t_bne++;
         if (jump)            t_jmp++;
         if (alu_op == 2'b01) t_aoc++;
         if (alu_op == 2'b10) t_aor++;
         if (|{jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write, alu_op})
            t_other++;
         tick();
         en = 1'b0;
         imem_ready = 1'($urandom_range(0, 1));
         if (t_cyc >= 2) opcode = 4'($urandom);
         if (state == 3'd0) done = 1;
      end
      if (!done) chk("instr_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_and_check(input logic [3:0] op, input int nwait, input int e_cyc,
                                input int e_rw, input int e_mr, input int e_mw, input int e_il);
      logic [15:0] pre;
      logic [15:0] d;
      pre = retired_count;
      do_instr(op, nwait);
      d = retired_count - pre;
      chk($sformatf("op%0h_w%0d_cycles", op, nwait), t_cyc, e_cyc);
      chk($sformatf("op%0h_pc_write", op), t_pw, 1);
      chk($sformatf("op%0h_reg_write", op), t_rw, e_rw);
      chk($sformatf("op%0h_mem_read", op), t_mr, e_mr);
      chk($sformatf("op%0h_mem_write", op), t_mw, e_mw);
      chk($sformatf("op%0h_illegal", op), t_il, e_il);
      chk($sformatf("op%0h_retire_delta", op), 32'(d), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; opcode = 4'h2;
      #2;
      chk("por_state", 32'(state), 32'd0);
      chk("por_strobes", 32'(act_vec()), 32'd0);
      chk("por_count", 32'(retired_count), 32'd0);
      tick();
      rst_n = 1'b1;

      // R-type: states 0,1,2,4
      run_and_check(4'h2, 0, 4, 1, 0, 0, 0);
      chk("rtype_state_seq", t_seq, 84);
      chk("rtype_reg_dst", t_rd, 1);
      chk("rtype_aluop_r", t_aor, 1);
      chk("rtype_count_abs", 32'(retired_count), 32'd1);
      // Load with three wait cycles, then zero-wait
      run_and_check(4'h0, 3, 8, 1, 4, 0, 0);
      chk("ld_mem_to_reg", t_mtr, 1);
      run_and_check(4'h0, 0, 5, 1, 1, 0, 0);
      run_and_check(4'h1, 0, 4, 0, 0, 1, 0);
      run_and_check(4'h1, 2, 6, 0, 0, 3, 0);
      run_and_check(4'hB, 0, 3, 0, 0, 0, 0);
      chk("beq_strobe", t_beq, 1);
      chk("beq_aluop_cmp", t_aoc, 1);
      chk("beq_state_seq", t_seq, 10);
      run_and_check(4'hC, 0, 3, 0, 0, 0, 0);
      chk("bne_strobe", t_bne, 1);
      run_and_check(4'hD, 0, 3, 0, 0, 0, 0);
      chk("jmp_strobe", t_jmp, 1);
      run_and_check(4'hE, 0, 2, 0, 0, 0, 1);
      chk("illegal_no_other", t_other, 0);
      run_and_check(4'hA, 0, 2, 0, 0, 0, 1);
      run_and_check(4'hF, 0, 2, 0, 0, 0, 1);
      run_and_check(4'h9, 0, 4, 1, 0, 0, 0);

      // Reset during a stalled store
      en = 1'b1; imem_ready = 1'b1; opcode = 4'h1; dmem_ready = 1'b0;
      tick();
      en = 1'b0;
      tick();
      tick();
      #1;
      chk("st_in_mem", 32'(state), 32'd3);
      chk("st_mem_write", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_state", 32'(state), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_pc_write", 32'(pc_write), 32'd0);
      chk("rst_count", 32'(retired_count), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Pause in FETCH with en low
      en = 1'b0; imem_ready = 1'b1;
      tick();
      tick();
      #1;
      chk("pause_state", 32'(state), 32'd0);
      chk("pause_ir_write", 32'(ir_write), 32'd0);

      // Counter wrap: preload 0xFFFF, retire one jump
      force dut.r_retired = 16'hFFFF;
      #1;
      release dut.r_retired;
      m_count = 16'hFFFF;
      run_and_check(4'hD, 0, 3, 0, 0, 0, 0);
      chk("wrap_count", 32'(retired_count), 32'd0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         en         = ($urandom_range(0, 9) < 8);
         imem_ready = ($urandom_range(0, 3) != 0);
         dmem_ready = ($urandom_range(0, 2) == 0);
         opcode     = 4'($urandom);
         tick();
      end
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have port clk, input, 1, single system clock, all state updated on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port en, input, 1, run enable, sampled only in FETCH.
REQ-004 SHALL have port opcode, input, 4, instruction opcode from datapath IR.
REQ-005 SHALL have port imem_ready, input, 1, instruction memory data valid.
REQ-006 SHALL have port dmem_ready, input, 1, data memory access complete.
REQ-007 SHALL have outputs jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write, each 1 bit, datapath control strobes.
REQ-008 SHALL have output alu_op, 2, ALU class: 00 add (LD/ST/JMP), 01 compare (BEQ/BNE), 10 R-type via opcode.
REQ-009 SHALL have outputs ir_write (1, load IR) and pc_write (1, advance/redirect PC).
REQ-010 SHALL have outputs state (3, current FSM state), illegal (1, one-cycle pulse) and retired_count (16, retired instructions).

Function
REQ-011 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 unreachable and SHALL return to FETCH.
REQ-012 FETCH SHALL hold while en=0 or imem_ready=0; with en=1 and imem_ready=1, ir_write=1 for that cycle, next DECODE.
REQ-013 DECODE SHALL last one cycle and latch opcode into op_q; all later strobes SHALL derive from op_q, not live opcode.
REQ-014 Opcode map: 0000 LD, 0001 ST, 0010-1001 R-type, 1011 BEQ, 1100 BNE, 1101 JMP; 1010, 1110, 1111 illegal.
REQ-015 Illegal opcode in DECODE SHALL pulse illegal=1 and pc_write=1 for one cycle, next FETCH; no other strobe asserted.
REQ-016 EXEC SHALL drive alu_op per REQ-008, alu_src=1 for LD/ST, reg_dst=1 for R-type.
REQ-017 EXEC for BEQ/BNE/JMP SHALL assert beq/bne/jump respectively with pc_write=1, next FETCH.
REQ-018 EXEC for LD/ST SHALL go to MEM; for R-type to WB.
REQ-019 MEM SHALL hold mem_read (LD) or mem_write (ST), plus alu_src=1, until dmem_ready=1; exit cycle: ST asserts pc_write=1 and goes FETCH, LD goes WB.
REQ-020 WB SHALL assert reg_write=1 and pc_write=1, mem_to_reg=1 only for LD, next FETCH.
REQ-021 Zero-wait latency SHALL be: branch/JMP 3 cycles, R-type 4, ST 4, LD 5, illegal 2.
REQ-022 mem_read and mem_write SHALL never be asserted together; outputs not listed for a state SHALL be 0.
REQ-023 retired_count SHALL increment by 1 in each cycle pc_write=1, including illegal skips, wrapping 0xFFFF to 0x0000.
REQ-024 en deassertion outside FETCH SHALL not interrupt the current instruction; pause occurs at next FETCH.
REQ-025 opcode changes after DECODE SHALL have no effect until next DECODE.

Reset
REQ-026 rst_n=0 SHALL immediately force state=FETCH, op_q=0000, retired_count=0, all strobes, alu_op, illegal = 0.
REQ-027 Reset asserted mid-instruction, including during MEM wait, SHALL abandon it without pc_write or reg_write.
REQ-028 After rst_n rises, first ir_write SHALL occur no earlier than first rising edge with en=1 and imem_ready=1.

Structure
REQ-029 State encodings and opcode constants SHALL live in shared Parameter.v include, reused by datapath and ALU control.
REQ-030 One combinational sub-module, ctrl_decode (op_q, state -> strobes), SHALL be instantiated; FSM and counter stay in top.

Verification
REQ-031 Reset then en=1, imem_ready=1, opcode=0010 -> states 0,1,2,4; reg_dst=1, alu_op=10 in EXEC; reg_write=1, pc_write=1 in WB; retired_count=1.
REQ-032 opcode=0000, dmem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_to_reg=1, reg_write=1; total 8 cycles.
REQ-033 opcode=1011 -> EXEC asserts beq=1, alu_op=01, pc_write=1; back to FETCH at cycle 3; reg_write never 1.
REQ-034 opcode=1110 -> illegal=1, pc_write=1 in DECODE cycle only; retired_count +1; no strobe else.
REQ-035 rst_n pulsed low during MEM of ST (opcode=0001) -> state=FETCH asynchronously, mem_write=0, retired_count=0.
REQ-036 Preload 0xFFFF retirements (force or loop), one more JMP -> retired_count=0x0000; en=0 in FETCH -> state holds 0, ir_write=0.
